bidir_pad_ctrl: RTL and testbench
=================================

Name: bidir_pad_ctrl

Overview:
- Synchronous controller that owns one side of a bidirectional, tran-connected switch net. It drives the pad (A-side inout) for writes and releases it for reads.
- It inserts bus-turnaround cycles on direction changes and waits a settle interval that covers the switch path delay. It samples the net before returning a response.
- Sits directly upstream of the switch fabric. It is the only clocked agent that drives its inout port.

Parameters:
- W, 8, data and pad width in bits.
- SETTLE, 2, cycles the pad is driven or monitored before capture; legal range 1..15.
- TURN, 1, high-Z cycles inserted on any direction change; legal range 0..15; 0 means no turnaround.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  request accepted when req_valid and req_ready are both high at a clk edge.
- req_wr  input  1  1 = write (drive pad), 0 = read (sample pad).
- req_wdata  input  W  write data; latched on acceptance.
- rsp_valid  output  1  response present; held until accepted.
- rsp_ready  input  1  response consumed when rsp_valid and rsp_ready are both high at a clk edge.
- rsp_rdata  output  W  pad value captured at the end of the settle interval (writes return the readback).
- pad  inout  W  bidirectional net; driven with the latched data when pad_oe=1, otherwise 'z.
- pad_oe  output  1  drive enable, exported for observation.
- err  output  1  sticky readback error; see Optional Feature.

Behaviour:
- Interface is fixed: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset is asynchronous:
  - Assertion immediately forces pad_oe=0, pad='z, req_ready=0, rsp_valid=0, rsp_rdata=0, err=0, state=IDLE.
  - The direction flag resets to dir=READ.
  - Any in-flight operation is discarded with no response.
- After reset release, req_ready=1 from the first clk edge.
- States:
  - IDLE: req_ready=1.
  - TURN: pad_oe=0, counts TURN cycles.
  - DRIVE: pad_oe=1, counts SETTLE cycles.
  - SAMPLE: pad_oe=0, counts SETTLE cycles.
  - RESP: rsp_valid=1.
  - req_ready is 1 only in IDLE.
- On acceptance at edge E0:
  - Latch req_wr and req_wdata.
  - If the requested direction differs from dir and TURN>0, go to TURN; otherwise go straight to DRIVE (write) or SAMPLE (read).
  - After TURN, set dir to the new direction and go to DRIVE or SAMPLE.
- DRIVE/SAMPLE:
  - The counter loads SETTLE-1 on entry and decrements each cycle.
  - At the edge where the counter is 0, capture pad into rsp_rdata and go to RESP.
  - Captured X/Z bits are passed through unchanged.
- Latency from acceptance to rsp_valid high:
  - Same direction: SETTLE edges.
  - Direction change: TURN+SETTLE edges.
- RESP:
  - rsp_valid and rsp_rdata are held stable until rsp_valid and rsp_ready are both high at an edge; then go to IDLE.
  - No new request is accepted while a response is pending.
- Parking:
  - After a write, pad_oe stays 1 and keeps driving the last written value through RESP and IDLE, until a read is accepted.
  - After a read, pad_oe stays 0.
- Minimum op period, same direction, rsp_ready tied high: SETTLE+2 cycles.
- The counter width is sized for 15. Out-of-range parameters are a $fatal at elaboration.

Optional Feature:
- Macro: BIDIR_READBACK_CHK_EN.
- Enabled:
  - At the DRIVE capture edge, compare pad !== latched wdata (X/Z bits count as a mismatch).
  - On mismatch, set err=1; err stays 1 until rst_n is asserted.
  - rsp is still returned normally.
- Disabled: err is tied to 0 and no compare logic is generated.

Test Plan:
- W=8, SETTLE=2, TURN=1, rsp_ready=1, reset released. Write 0xA5 accepted at E0 -> pad_oe=0 E0..E1 (TURN), pad=0xA5 from after E1, rsp_valid high after E3 with rsp_rdata=0xA5; pad stays 0xA5 in IDLE.
- Then read while an external driver puts 0x3C on the far switch node -> pad_oe drops after acceptance, one TURN cycle, 2 SAMPLE cycles, rsp_rdata=0x3C, pad_oe remains 0.
- Back-to-back writes 0x01 then 0x02 -> no TURN between them; second rsp_valid exactly 2 edges after its acceptance; pad goes 0x01 to 0x02.
- Read with rsp_ready held 0 for 5 cycles -> rsp_valid stays 1, rsp_rdata stable, req_ready=0; a pending req_valid is not accepted until the cycle after the rsp handshake.
- Assert rst_n=0 asynchronously mid-DRIVE of 0xFF -> pad_oe=0 and pad='z with no clk edge; rsp_valid=0; after release, a write of 0x10 incurs a TURN cycle.
- With BIDIR_READBACK_CHK_EN: external strong driver forces 0x00 during a write of 0xFF -> err=1 after the capture edge and held through later ops. Without the macro, the same stimulus gives err=0.

Source files
------------

// File: rtl/bidir_pad_ctrl.sv
// bidir_pad_ctrl: owns the A side of a bidirectional switch net.
// Drives the pad for writes and releases it for reads. Inserts high-Z
// turnaround cycles on direction changes. Waits a settle interval before
// capturing the net into the response.
// Optional feature macro: BIDIR_READBACK_CHK_EN (sticky write readback error).
module bidir_pad_ctrl #(
    parameter int W      = 8,
    parameter int SETTLE = 2,
    parameter int TURN   = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_wr,
    input  logic [W-1:0] req_wdata,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_rdata,
    inout  wire  [W-1:0] pad,
    output logic         pad_oe,
    output logic         err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TURN,
        S_DRIVE,
        S_SAMPLE,
        S_RESP
    } state_t;

    // Counters are 4 bits wide, so both intervals must fit in 1..15 / 0..15.
    if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
        $fatal(1, "bidir_pad_ctrl: SETTLE=%0d outside 1..15", SETTLE);
    end
    if (TURN < 0 || TURN > 15) begin : g_bad_turn
        $fatal(1, "bidir_pad_ctrl: TURN=%0d outside 0..15", TURN);
    end

    localparam logic [3:0] SETTLE_LD = 4'(SETTLE - 1);
    localparam logic [3:0] TURN_LD   = 4'((TURN > 0) ? TURN - 1 : 0);
    localparam bit         HAS_TURN  = (TURN > 0);

    // dir_q: 1 = write (pad driven / parked), 0 = read (pad released)
    state_t         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic           dir_q, dir_d;
    logic           wr_q, wr_d;
    logic [W-1:0]   wdata_q, wdata_d;
    logic [W-1:0]   rdata_q, rdata_d;
    logic           ready_q;

    // Ready is held low through reset and rises at the first clock edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
        end
    end

    // Main state and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            dir_q   <= 1'b0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Next-state logic: accept, optional turnaround, settle count, capture, respond.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    wr_d = req_wr;
                    if (req_wr) begin
                        wdata_d = req_wdata;
                    end
                    if (HAS_TURN && (req_wr != dir_q)) begin
                        state_d = S_TURN;
                        cnt_d   = TURN_LD;
                    end else begin
                        dir_d   = req_wr;
                        cnt_d   = SETTLE_LD;
                        state_d = req_wr ? S_DRIVE : S_SAMPLE;
                    end
                end
            end
            S_TURN: begin
                if (cnt_q == 4'd0) begin
                    dir_d   = wr_q;
                    cnt_d   = SETTLE_LD;
                    state_d = wr_q ? S_DRIVE : S_SAMPLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DRIVE, S_SAMPLE: begin
                if (cnt_q == 4'd0) begin
                    rdata_d = pad;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

`ifdef BIDIR_READBACK_CHK_EN
    logic err_q;

    // Sticky readback check at the write capture edge; X/Z on the pad counts as a mismatch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (state_q == S_DRIVE && cnt_q == 4'd0 && (pad !== wdata_q)) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // The pad is driven while settling a write and stays parked on the last
    // written value in RESP/IDLE until a read turns it around.
    assign pad_oe    = (state_q == S_DRIVE) ||
                       (((state_q == S_IDLE) || (state_q == S_RESP)) && dir_q);
    assign pad       = pad_oe ? wdata_q : {W{1'bz}};
    assign req_ready = ready_q && (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_bidir_pad_ctrl.sv
// tb_bidir_pad_ctrl: scoreboard bench for bidir_pad_ctrl (W=8, SETTLE=2, TURN=1).
// An external tristate driver stands in for the far side of the switch net.
module tb_bidir_pad_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic       req_wr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_rdata;
    wire  [7:0] pad;
    logic       pad_oe;
    logic       err;

    logic       ext_en;
    logic [7:0] ext_val;

    int         tests;
    int         fails;
    logic [7:0] sb[$];

`ifdef BIDIR_READBACK_CHK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    assign pad = ext_en ? ext_val : 8'bz;

    bidir_pad_ctrl #(.W(8), .SETTLE(2), .TURN(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wr    (req_wr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .pad       (pad),
        .pad_oe    (pad_oe),
        .err       (err)
    );

    // 100 MHz-style free-running clock
    always #5 clk = ~clk;

    // Hard stop in case something wedges outside the bounded waits
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] pop_exp();
        if (sb.size() > 0) return sb.pop_front();
        return 8'hxx;
    endfunction

    // Present a request until accepted; expected response data goes to the scoreboard
    task automatic issue_req(input logic wr, input logic [7:0] data,
                             input logic [7:0] exp_rd, output bit ok);
        logic rdy;
        req_valid = 1'b1;
        req_wr    = wr;
        req_wdata = data;
        ok        = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            rdy = req_ready;
            step();
            if (rdy) ok = 1'b1;
        end
        req_valid = 1'b0;
        req_wdata = 8'h00;
        if (ok) sb.push_back(exp_rd);
    endtask

    // Count clock edges from acceptance until rsp_valid rises
    task automatic wait_rsp(input int start, output int lat, output bit ok);
        lat = start;
        while (!rsp_valid && lat < 100) begin
            step();
            lat++;
        end
        ok = rsp_valid;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_wr    = 1'b0;
        req_wdata = 8'h00;
        rsp_ready = 1'b1;
        ext_en    = 1'b0;
        ext_val   = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        tests++; if (pad_oe !== 1'b0) begin fails++; $display("[TB] FAIL reset_pad_oe: got %b expected 0", pad_oe); end
        tests++; if (req_ready !== 1'b0) begin fails++; $display("[TB] FAIL reset_req_ready: got %b expected 0", req_ready); end
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        tests++; if (rsp_rdata !== 8'h00) begin fails++; $display("[TB] FAIL reset_rsp_rdata: got %h expected 00", rsp_rdata); end
        tests++; if (err !== 1'b0) begin fails++; $display("[TB] FAIL reset_err: got %b expected 0", err); end
        #2 rst_n = 1'b1;
        #1;
        tests++; if (req_ready !== 1'b0) begin fails++; $display("[TB] FAIL ready_before_edge: got %b expected 0", req_ready); end
        step();
        tests++; if (req_ready !== 1'b1) begin fails++; $display("[TB] FAIL ready_after_edge: got %b expected 1", req_ready); end
    endtask

    task automatic test_write_turn();
        bit         ok;
        int         lat;
        logic [7:0] exp;
        issue_req(1'b1, 8'hA5, 8'hA5, ok);
        tests++; if (ok !== 1'b1) begin fails++; $display("[TB] FAIL wr_accept: got %b expected 1", ok); end
        tests++; if (pad_oe !== 1'b0) begin fails++; $display("[TB] FAIL wr_turn_oe: got %b expected 0", pad_oe); end
        step();
        tests++; if (pad_oe !== 1'b1) begin fails++; $display("[TB] FAIL wr_drive_oe: got %b expected 1", pad_oe); end
        tests++; if (pad !== 8'hA5) begin fails++; $display("[TB] FAIL wr_drive_pad: got %h expected a5", pad); end
        wait_rsp(1, lat, ok);
        tests++; if (lat !== 3) begin fails++; $display("[TB] FAIL wr_turn_latency: got %0d expected 3", lat); end
        exp = pop_exp();
        tests++; if (rsp_rdata !== exp) begin fails++; $display("[TB] FAIL wr_rdata: got %h expected %h", rsp_rdata, exp); end
        step();
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("[TB] FAIL wr_rsp_done: got %b expected 0", rsp_valid); end
        tests++; if (req_ready !== 1'b1) begin fails++; $display("[TB] FAIL wr_idle_ready: got %b expected 1", req_ready); end
        tests++; if (pad !== 8'hA5 || pad_oe !== 1'b1) begin fails++; $display("[TB] FAIL wr_park: got pad %h oe %b expected a5 1", pad, pad_oe); end
    endtask

    task automatic test_read();
        bit         ok;
        int         lat;
        logic [7:0] exp;
        issue_req(1'b0, 8'h00, 8'h3C, ok);
        tests++; if (pad_oe !== 1'b0) begin fails++; $display("[TB] FAIL rd_oe_drop: got %b expected 0", pad_oe); end
        ext_val = 8'h3C;
        ext_en  = 1'b1;
        wait_rsp(0, lat, ok);
        tests++; if (lat !== 3) begin fails++; $display("[TB] FAIL rd_latency: got %0d expected 3", lat); end
        exp = pop_exp();
        tests++; if (rsp_rdata !== exp) begin fails++; $display("[TB] FAIL rd_rdata: got %h expected %h", rsp_rdata, exp); end
        step();
        tests++; if (pad_oe !== 1'b0) begin fails++; $display("[TB] FAIL rd_park: got %b expected 0", pad_oe); end
        ext_en = 1'b0;
    endtask

    task automatic test_back_to_back();
        bit         ok;
        int         lat;
        logic [7:0] exp;
        issue_req(1'b1, 8'h01, 8'h01, ok);
        wait_rsp(0, lat, ok);
        tests++; if (lat !== 3) begin fails++; $display("[TB] FAIL b2b_first_latency: got %0d expected 3", lat); end
        exp = pop_exp();
        tests++; if (rsp_rdata !== exp) begin fails++; $display("[TB] FAIL b2b_first_rdata: got %h expected %h", rsp_rdata, exp); end
        step();
        tests++; if (pad !== 8'h01) begin fails++; $display("[TB] FAIL b2b_park_01: got %h expected 01", pad); end
        issue_req(1'b1, 8'h02, 8'h02, ok);
        tests++; if (pad !== 8'h02 || pad_oe !== 1'b1) begin fails++; $display("[TB] FAIL b2b_no_turn: got pad %h oe %b expected 02 1", pad, pad_oe); end
        wait_rsp(0, lat, ok);
        tests++; if (lat !== 2) begin fails++; $display("[TB] FAIL b2b_second_latency: got %0d expected 2", lat); end
        exp = pop_exp();
        tests++; if (rsp_rdata !== exp) begin fails++; $display("[TB] FAIL b2b_second_rdata: got %h expected %h", rsp_rdata, exp); end
        step();
    endtask

    task automatic test_backpressure();
        bit         ok;
        int         lat;
        logic [7:0] exp;
        rsp_ready = 1'b0;
        issue_req(1'b0, 8'h00, 8'h5A, ok);
        ext_val = 8'h5A;
        ext_en  = 1'b1;
        wait_rsp(0, lat, ok);
        tests++; if (lat !== 3) begin fails++; $display("[TB] FAIL bp_latency: got %0d expected 3", lat); end
        exp       = pop_exp();
        req_valid = 1'b1;
        req_wr    = 1'b1;
        req_wdata = 8'h77;
        for (int i = 0; i < 5; i++) begin
            tests++; if (rsp_valid !== 1'b1) begin fails++; $display("[TB] FAIL bp_hold_valid[%0d]: got %b expected 1", i, rsp_valid); end
            tests++; if (rsp_rdata !== exp) begin fails++; $display("[TB] FAIL bp_hold_rdata[%0d]: got %h expected %h", i, rsp_rdata, exp); end
            tests++; if (req_ready !== 1'b0) begin fails++; $display("[TB] FAIL bp_no_ready[%0d]: got %b expected 0", i, req_ready); end
            step();
        end
        rsp_ready = 1'b1;
        step();
        ext_en = 1'b0;
        tests++; if (rsp_valid !== 1'b0) begin fails++; $display("[TB] FAIL bp_rsp_consumed: got %b expected 0", rsp_valid); end
        tests++; if (req_ready !== 1'b1) begin fails++; $display("[TB] FAIL bp_not_yet_accepted: got %b expected 1", req_ready); end
        step();
        tests++; if (req_ready !== 1'b0) begin fails++; $display("[TB] FAIL bp_pending_accepted: got %b expected 0", req_ready); end
        sb.push_back(8'h77);
        req_valid = 1'b0;
        wait_rsp(0, lat, ok);
        tests++; if (lat !== 3) begin fails++; $display("[TB] FAIL bp_wr_latency: got %0d expected 3", lat); end
        exp = pop_exp();
        tests++; if (rsp_rdata !== exp) begin fails++; $display("[TB] FAIL bp_wr_rdata: got %h expected %h", rsp_rdata, exp); end
        step();
    endtask

    task automatic test_async_reset();
        bit         ok;
        int         lat;
        logic [7:0] exp;
        issue_req(1'b1, 8'hFF, 8'hFF, ok);
        tests++; if (pad_oe !== 1'b1) begin fails++; $display("[TB] FAIL ar_drive_oe: got %b expected 1", pad_oe); end
        #2 rst_n = 1'b0;
        #1;
        tests++; if (pad_oe !== 1'b0) begin fails++; $display("[TB] FAIL ar_oe_async: got %b expected 0", pad_oe); end
        tests++; if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin fails++; $display("[TB] FAIL ar_handshake: got valid %b ready %b expected 0 0", rsp_valid, req_ready); end
        ext_val = 8'hC3;
        ext_en  = 1'b1;
        #1;
        tests++; if (pad !== 8'hC3) begin fails++; $display("[TB] FAIL ar_pad_released: got %h expected c3", pad); end
        ext_en = 1'b0;
        sb.delete();
        @(posedge clk);
        #3 rst_n = 1'b1;
        step();
        issue_req(1'b1, 8'h10, 8'h10, ok);
        tests++; if (pad_oe !== 1'b0) begin fails++; $display("[TB] FAIL ar_turn_oe: got %b expected 0", pad_oe); end
        wait_rsp(0, lat, ok);
        tests++; if (lat !== 3) begin fails++; $display("[TB] FAIL ar_turn_latency: got %0d expected 3", lat); end
        exp = pop_exp();
        tests++; if (rsp_rdata !== exp) begin fails++; $display("[TB] FAIL ar_rdata: got %h expected %h", rsp_rdata, exp); end
        step();
    endtask

    task automatic test_readback_chk();
        bit         ok;
        int         lat;
        logic [7:0] exp;
        issue_req(1'b1, 8'hFF, 8'hFF, ok);
        ext_val = 8'h00;
        ext_en  = 1'b1;
        wait_rsp(0, lat, ok);
        tests++; if (lat !== 2) begin fails++; $display("[TB] FAIL rb_latency: got %0d expected 2", lat); end
        exp    = pop_exp();
        ext_en = 1'b0;
        tests++; if (err !== EXP_ERR) begin fails++; $display("[TB] FAIL rb_err_set: got %b expected %b", err, EXP_ERR); end
        step();
        issue_req(1'b1, 8'h22, 8'h22, ok);
        wait_rsp(0, lat, ok);
        exp = pop_exp();
        tests++; if (rsp_rdata !== exp) begin fails++; $display("[TB] FAIL rb_next_rdata: got %h expected %h", rsp_rdata, exp); end
        tests++; if (err !== EXP_ERR) begin fails++; $display("[TB] FAIL rb_err_sticky: got %b expected %b", err, EXP_ERR); end
        step();
    endtask

    // Run each scenario in order, then report
    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_write_turn();
        test_read();
        test_back_to_back();
        test_backpressure();
        test_async_reset();
        test_readback_chk();
        tests++; if (sb.size() !== 0) begin fails++; $display("[TB] FAIL scoreboard_drain: got %0d entries expected 0", sb.size()); end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
